pc_sequencer: RTL and testbench

Controller that owns the 32-bit program counter of the fetch stage and sequences every change to it. Sources are reset-vector load, sequential increment, stall hold, taken jump, interrupt entry and RET/RTI return. It drives the instruction-memory address, and tells the fetch/decode buffer when the fetched word is valid and when in-flight instructions must be flushed. Instruction memory is 16 bits wide and combinational-read, so 32-bit vectors are fetched as two words: high word first, then low word.

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter sequencer
// Owns PC; loads reset/interrupt vectors as two 16-bit words and handles jump, stall, interrupt and return.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
    parameter logic [31:0] INT_VEC_ADDR   = 32'd2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] MemData,
    input  logic        Stall,
    input  logic        JmpTaken,
    input  logic [31:0] JmpTarget,
    input  logic        IntReq,
    input  logic        RetRti,
    input  logic        RetValid,
    input  logic [31:0] RetAddr,
    output logic [31:0] MemAddr,
    output logic [31:0] PC,
    output logic        FetchValid,
    output logic        Flush,
    output logic        IntAck,
    output logic [31:0] IntRetPC
);

    typedef enum logic [2:0] {
        RST_HI   = 3'd0,
        RST_LO   = 3'd1,
        RUN      = 3'd2,
        INT_HI   = 3'd3,
        INT_LO   = 3'd4,
        RET_WAIT = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_int_ret_pc;
    logic [15:0] r_vec_hi;
    logic        r_int_pending;
    logic        r_intreq_d;

    logic        w_in_run;
    logic        w_int_take;
    logic        w_int_edge;

    assign w_int_edge = IntReq & ~r_intreq_d;

    // Interrupt acceptance loses to jump and return, and waits out a stall.
    always_comb begin
        w_in_run   = (r_state == RUN) && !Rst;
        w_int_take = w_in_run && !JmpTaken && !RetRti && r_int_pending && !Stall;
        Flush      = w_in_run && (JmpTaken || RetRti || w_int_take);
        FetchValid = w_in_run && !JmpTaken && !RetRti && !w_int_take;
        IntAck     = w_int_take;
    end

    always_comb begin
        MemAddr = r_pc;
        case (r_state)
            RST_HI:  MemAddr = RESET_VEC_ADDR;
            RST_LO:  MemAddr = RESET_VEC_ADDR + 32'd1;
            INT_HI:  MemAddr = INT_VEC_ADDR;
            INT_LO:  MemAddr = INT_VEC_ADDR + 32'd1;
            default: MemAddr = r_pc;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= RST_HI;
            r_pc          <= 32'd0;
            r_int_ret_pc  <= 32'd0;
            r_vec_hi      <= 16'd0;
            r_int_pending <= 1'b0;
            r_intreq_d    <= 1'b0;
        end else begin
            r_intreq_d    <= IntReq;
            r_int_pending <= w_int_edge || (r_int_pending && !w_int_take);
            case (r_state)
                RST_HI: begin
                    r_vec_hi <= MemData;
                    r_state  <= RST_LO;
                end
                RST_LO: begin
                    r_pc    <= {r_vec_hi, MemData};
                    r_state <= RUN;
                end
                INT_HI: begin
                    r_vec_hi <= MemData;
                    r_state  <= INT_LO;
                end
                INT_LO: begin
                    r_pc    <= {r_vec_hi, MemData};
                    r_state <= RUN;
                end
                RUN: begin
                    if (JmpTaken) begin
                        r_pc <= JmpTarget;
                    end else if (RetRti) begin
                        r_state <= RET_WAIT;
                    end else if (w_int_take) begin
                        r_int_ret_pc <= r_pc;
                        r_state      <= INT_HI;
                    end else if (!Stall) begin
                        r_pc <= r_pc + 32'd1;
                    end
                end
                RET_WAIT: begin
                    if (RetValid) begin
                        r_pc    <= RetAddr;
                        r_state <= RUN;
                    end
                end
                default: r_state <= RST_HI;
            endcase
        end
    end

    assign PC       = r_pc;
    assign IntRetPC = r_int_ret_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] MemData;
    logic        Stall;
    logic        JmpTaken;
    logic [31:0] JmpTarget;
    logic        IntReq;
    logic        RetRti;
    logic        RetValid;
    logic [31:0] RetAddr;
    logic [31:0] MemAddr;
    logic [31:0] PC;
    logic        FetchValid;
    logic        Flush;
    logic        IntAck;
    logic [31:0] IntRetPC;

    logic [15:0] mem [0:3];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign MemData = (MemAddr < 32'd4) ? mem[MemAddr[1:0]] : 16'h0000;

    pc_sequencer dut (
        .Clk(Clk), .Rst(Rst), .MemData(MemData), .Stall(Stall),
        .JmpTaken(JmpTaken), .JmpTarget(JmpTarget), .IntReq(IntReq),
        .RetRti(RetRti), .RetValid(RetValid), .RetAddr(RetAddr),
        .MemAddr(MemAddr), .PC(PC), .FetchValid(FetchValid), .Flush(Flush),
        .IntAck(IntAck), .IntRetPC(IntRetPC)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        mem[0] = 16'h0000; mem[1] = 16'h0010;
        mem[2] = 16'h0000; mem[3] = 16'h0100;
        Rst = 1'b1; Stall = 0; JmpTaken = 0; JmpTarget = 0; IntReq = 0;
        RetRti = 0; RetValid = 0; RetAddr = 0;
        tick(); tick();
        settle();
        chk("rst_fetchvalid", {31'd0, FetchValid}, 32'd0);
        chk("rst_flush", {31'd0, Flush}, 32'd0);
        chk("rst_intack", {31'd0, IntAck}, 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_intretpc", IntRetPC, 32'd0);

        // Release reset: cycle 0 RST_HI, 1 RST_LO, 2 RUN
        tick(); Rst = 0; settle();
        chk("c0_memaddr", MemAddr, 32'd0);
        chk("c0_fetchvalid", {31'd0, FetchValid}, 32'd0);
        tick(); settle();
        chk("c1_memaddr", MemAddr, 32'd1);
        tick(); settle();
        chk("c2_pc", PC, 32'h10);
        chk("c2_fetchvalid", {31'd0, FetchValid}, 32'd1);
        chk("c2_memaddr", MemAddr, 32'h10);
        tick(); settle();
        chk("c3_pc", PC, 32'h11);

        // Jump to 0x20, then jump wins over stall
        JmpTaken = 1; JmpTarget = 32'h20; settle();
        chk("jmp_flush", {31'd0, Flush}, 32'd1);
        chk("jmp_fetchvalid", {31'd0, FetchValid}, 32'd0);
        tick(); JmpTaken = 0; settle();
        chk("jmp_pc", PC, 32'h20);
        chk("jmp_next_fetchvalid", {31'd0, FetchValid}, 32'd1);
        Stall = 1; JmpTaken = 1; JmpTarget = 32'h80; settle();
        chk("jmpstall_flush", {31'd0, Flush}, 32'd1);
        tick(); JmpTaken = 0; settle();
        chk("jmpstall_pc", PC, 32'h80);
        chk("stall_fetchvalid", {31'd0, FetchValid}, 32'd1);
        chk("stall_flush", {31'd0, Flush}, 32'd0);
        tick(); Stall = 0; settle();
        chk("stall_hold_pc", PC, 32'h80);

        // Interrupt held off by a two-cycle stall
        JmpTaken = 1; JmpTarget = 32'h40; settle();
        tick(); JmpTaken = 0; Stall = 1; IntReq = 1; settle();
        chk("int_pc40", PC, 32'h40);
        chk("int_noack_edge", {31'd0, IntAck}, 32'd0);
        tick(); IntReq = 0; settle();
        chk("int_noack_stall", {31'd0, IntAck}, 32'd0);
        chk("int_stall_pc", PC, 32'h40);
        tick(); Stall = 0; settle();
        chk("int_ack", {31'd0, IntAck}, 32'd1);
        chk("int_ack_flush", {31'd0, Flush}, 32'd1);
        chk("int_ack_fetchvalid", {31'd0, FetchValid}, 32'd0);
        tick(); settle();
        chk("int_hi_memaddr", MemAddr, 32'd2);
        chk("int_retpc", IntRetPC, 32'h40);
        chk("int_hi_intack", {31'd0, IntAck}, 32'd0);
        tick(); settle();
        chk("int_lo_memaddr", MemAddr, 32'd3);
        tick(); settle();
        chk("int_vec_pc", PC, 32'h100);
        chk("int_vec_fetchvalid", {31'd0, FetchValid}, 32'd1);

        // Return with interrupt edge during the wait
        for (int i = 0; i < 5; i++) tick();
        settle();
        chk("ret_pc105", PC, 32'h105);
        RetRti = 1; RetValid = 1; RetAddr = 32'h41; settle();
        chk("ret_flush", {31'd0, Flush}, 32'd1);
        tick(); RetRti = 0; RetValid = 0; JmpTaken = 1; JmpTarget = 32'h999;
        Stall = 1; IntReq = 1; settle();
        chk("retw_pc", PC, 32'h105);
        chk("retw_fetchvalid1", {31'd0, FetchValid}, 32'd0);
        chk("retw_flush", {31'd0, Flush}, 32'd0);
        tick(); IntReq = 0; settle();
        chk("retw_fetchvalid2", {31'd0, FetchValid}, 32'd0);
        chk("retw_memaddr", MemAddr, 32'h105);
        tick(); settle();
        chk("retw_fetchvalid3", {31'd0, FetchValid}, 32'd0);
        tick(); JmpTaken = 0; Stall = 0; RetValid = 1; settle();
        chk("retw_fetchvalid4", {31'd0, FetchValid}, 32'd0);
        tick(); RetValid = 0; settle();
        chk("ret_pc", PC, 32'h41);
        chk("ret_int_taken", {31'd0, IntAck}, 32'd1);

        // Reset during INT_LO with a pending interrupt latched in INT_HI
        tick(); IntReq = 1; settle();
        chk("int2_retpc", IntRetPC, 32'h41);
        tick(); IntReq = 0; Rst = 1; settle();
        chk("midrst_fetchvalid", {31'd0, FetchValid}, 32'd0);
        chk("midrst_flush", {31'd0, Flush}, 32'd0);
        chk("midrst_intack", {31'd0, IntAck}, 32'd0);
        tick(); Rst = 0; settle();
        chk("midrst_memaddr", MemAddr, 32'd0);
        chk("midrst_pc", PC, 32'd0);
        chk("midrst_intretpc", IntRetPC, 32'd0);
        tick(); tick(); settle();
        chk("midrst_run_pc", PC, 32'h10);
        chk("midrst_no_pending", {31'd0, IntAck}, 32'd0);
        chk("midrst_run_fetchvalid", {31'd0, FetchValid}, 32'd1);

        // PC wrap
        JmpTaken = 1; JmpTarget = 32'hFFFF_FFFF; settle();
        tick(); JmpTaken = 0; settle();
        chk("wrap_pre", PC, 32'hFFFF_FFFF);
        tick(); settle();
        chk("wrap_pc", PC, 32'd0);

        // IntReq held high triggers once
        IntReq = 1;
        tick(); settle();
        chk("held_ack", {31'd0, IntAck}, 32'd1);
        tick(); tick(); tick(); settle();
        chk("held_vec_pc", PC, 32'h100);
        chk("held_noack1", {31'd0, IntAck}, 32'd0);
        tick(); settle();
        chk("held_noack2", {31'd0, IntAck}, 32'd0);
        chk("held_pc", PC, 32'h101);
        IntReq = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
